mont_modexp_ctrl: RTL



---
 rtl/mont_pkg.sv | 39 +++
 rtl/mont_modexp_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mont_pkg.sv
// mont_pkg
//   Shared definitions for the Montgomery modular-exponentiation slice
//   (M = 65521, R = 2^16). Imported by the exponentiation sequencer and by
//   the pipelined Montgomery multiplier that sits beside it.
//   Contents:
//     M, M_PRIME, R_MOD_M, R2_MOD_M : modulus constants (all 16 bits)
//     state_t                       : sequencer FSM states
//     phase_t                       : per-multiply ISSUE/WAIT phase
//     reduce_once()                 : maps 0..65535 into 0..M-1
package mont_pkg;

    localparam logic [15:0] M        = 16'd65521;
    // -M^-1 mod R, consumed by the multiplier's REDC step
    localparam logic [15:0] M_PRIME  = 16'd61167;
    // Montgomery form of 1
    localparam logic [15:0] R_MOD_M  = 16'd15;
    // MM(x, R^2) converts x into the Montgomery domain
    localparam logic [15:0] R2_MOD_M = 16'd225;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TO_MONT   = 3'd1,
        SQ        = 3'd2,
        MUL       = 3'd3,
        FROM_MONT = 3'd4,
        DONE      = 3'd5
    } state_t;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } phase_t;

    // Any 16-bit value is below 2*M, so one conditional subtract suffices.
    function automatic logic [15:0] reduce_once(input logic [15:0] x);
        return (x >= M) ? (x - M) : x;
    endfunction

endpackage

// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl
//   Square-and-multiply sequencer computing result = base^exp mod 65521.
//   Feeds the Montgomery multiplier one operation at a time and consumes its
//   result; latency-agnostic (always waits for mm_valid, bounded by a timeout).
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both 1. The producer holds its data stable while
//   valid is high and ready is low; ready never depends on the same-cycle
//   valid from the other side.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid / in_ready  request handshake (in_ready = block idle)
//     base, exp            request operands
//     out_valid/out_ready  result handshake
//     result, err          base^exp mod M; err = multiplier timeout
//     mm_a, mm_b, mm_start operands and one-cycle issue pulse to multiplier
//     mm_result, mm_valid  multiplier output
//     dbg_state            current FSM state, for observation only
module mont_modexp_ctrl
    import mont_pkg::*;
#(
    parameter int EXP_W      = 16,
    parameter int MM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      base,
    input  logic [EXP_W-1:0] exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             err,
    output logic [15:0]      mm_a,
    output logic [15:0]      mm_b,
    output logic             mm_start,
    input  logic [15:0]      mm_result,
    input  logic             mm_valid,
    output state_t           dbg_state
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int CNT_W = (MM_TIMEOUT > 1) ? $clog2(MM_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(EXP_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_TIMEOUT - 1);

    state_t            state;
    phase_t            phase;
    logic [15:0]       base_r;
    logic [EXP_W-1:0]  exp_r;
    logic [IDX_W-1:0]  idx;
    logic [15:0]       bm;
    logic [15:0]       acc;
    logic [CNT_W-1:0]  wait_cnt;
    logic              op_state;
    logic              last_bit;

    assign op_state  = (state == TO_MONT) || (state == SQ) ||
                       (state == MUL) || (state == FROM_MONT);
    assign last_bit  = (idx == '0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // Operands come straight from the held registers, so they stay stable
    // for the whole WAIT phase without extra capture flops.
    always_comb begin
        mm_a     = '0;
        mm_b     = '0;
        mm_start = 1'b0;
        if (op_state) begin
            mm_start = (phase == ISSUE);
        end
        case (state)
            TO_MONT: begin
                mm_a = base_r;
                mm_b = R2_MOD_M;
            end
            SQ: begin
                mm_a = acc;
                mm_b = acc;
            end
            MUL: begin
                mm_a = acc;
                mm_b = bm;
            end
            FROM_MONT: begin
                mm_a = acc;
                mm_b = 16'd1;
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= ISSUE;
            base_r   <= '0;
            exp_r    <= '0;
            idx      <= '0;
            bm       <= '0;
            acc      <= '0;
            wait_cnt <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        base_r <= reduce_once(base);
                        exp_r  <= exp;
                        idx    <= IDX_MSB;
                        acc    <= R_MOD_M;
                        err    <= 1'b0;
                        phase  <= ISSUE;
                        state  <= TO_MONT;
                    end
                end

                TO_MONT, SQ, MUL, FROM_MONT: begin
                    if (phase == ISSUE) begin
                        phase    <= WAIT;
                        wait_cnt <= '0;
                    end else if (mm_valid) begin
                        phase <= ISSUE;
                        case (state)
                            TO_MONT: begin
                                bm    <= mm_result;
                                state <= (exp_r == '0) ? FROM_MONT : SQ;
                            end
                            SQ: begin
                                acc <= mm_result;
                                if (exp_r[idx]) begin
                                    state <= MUL;
                                end else if (last_bit) begin
                                    state <= FROM_MONT;
                                end else begin
                                    idx   <= idx - 1'b1;
                                    state <= SQ;
                                end
                            end
                            MUL: begin
                                acc <= mm_result;
                                if (last_bit) begin
                                    state <= FROM_MONT;
                                end else begin
                                    idx   <= idx - 1'b1;
                                    state <= SQ;
                                end
                            end
                            default: begin
                                // FROM_MONT: leave the Montgomery domain
                                result <= mm_result;
                                state  <= DONE;
                            end
                        endcase
                    end else if (wait_cnt == CNT_LAST) begin
                        // Multiplier never answered: abort with a clean zero.
                        phase  <= ISSUE;
                        result <= '0;
                        err    <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    phase <= ISSUE;
                end
            endcase
        end
    end

endmodule
